// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: opcode constants, default widths and sequencer
// state encodings used by the ALU front-end and later datapath control.
package alu_defs_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned OP_W_DEF   = 4;
  localparam int unsigned CNT_W      = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_NEG = 4'b0011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_B  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_seq_settle_counter.sv
// 4-bit load/decrement counter with a registered terminal-count flag.
// Ports:
//   clock, clear : clock and synchronous active-high reset
//   load         : load load_val (has priority over dec)
//   load_val     : value to load
//   dec          : decrement by one, saturating at zero
//   tc           : high while the count equals 1
module alu_seq_settle_counter
  import alu_defs_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // tc is computed from the next count so it is valid the cycle the count is 1.
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_q <= '0;
      tc    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc    <= (cnt_d == CNT_W'(1));
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator-side front end for the combinational ALU. Collects operand A plus
// opcode, then operand B, from a valid/ready bus; holds them on the ALU inputs
// for SETTLE_CYCLES; captures the ALU result into a Z register and offers it
// on a valid/ready result port.
// Optional feature macro: ALU_OPCODE_CHECK_EN (illegal-opcode detection).
// Ports:
//   clock, clear        : clock and synchronous active-high reset
//   bus_in, op_in       : operand beat data / opcode (opcode with A beat only)
//   bus_valid, bus_ready: operand beat handshake
//   alu_a, alu_b        : registered operands to the ALU
//   alu_opcode          : registered opcode to the ALU
//   alu_result          : combinational ALU output
//   res_out, res_valid  : captured result and its valid
//   res_ready           : consumer accepts result
//   busy                : sequencer not idle
//   err                 : illegal opcode flag for the current result
module alu_op_sequencer
  import alu_defs_pkg::*;
#(
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned OP_W          = OP_W_DEF,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [OP_W-1:0]   op_in,
  input  logic              bus_valid,
  output logic              bus_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] res_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned      SETTLE_EFF  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_EFF);

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] b_d;
  logic [OP_W-1:0]   op_d;
  logic [DATA_W-1:0] res_d;
  logic              err_d;
  logic              ill_q;
  logic              ill_d;
  logic              op_illegal_c;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_tc;

`ifdef ALU_OPCODE_CHECK_EN
  localparam logic [OP_W-1:0] OP_MAX = OP_W'(OP_NEG);
  assign op_illegal_c = (op_in > OP_MAX);
`else
  assign op_illegal_c = 1'b0;
`endif

  alu_seq_settle_counter u_settle_cnt (
    .clock    (clock),
    .clear    (clear),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    a_d      = alu_a;
    b_d      = alu_b;
    op_d     = alu_opcode;
    res_d    = res_out;
    err_d    = err;
    ill_d    = ill_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_valid) begin
          a_d     = bus_in;
          op_d    = op_in;
          ill_d   = op_illegal_c;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (bus_valid) begin
          b_d = bus_in;
          // An illegal opcode skips the settle window with a zero result.
          if (ill_q) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_load = 1'b1;
            state_d  = SETTLE;
          end
        end
      end
      SETTLE: begin
        cnt_dec = 1'b1;
        if (cnt_tc) begin
          res_d   = alu_result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          err_d   = 1'b0;
          ill_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; handshake flags follow the next state.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      res_out    <= '0;
      err        <= 1'b0;
      ill_q      <= 1'b0;
      bus_ready  <= 1'b1;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a      <= a_d;
      alu_b      <= b_d;
      alu_opcode <= op_d;
      res_out    <= res_d;
      err        <= err_d;
      ill_q      <= ill_d;
      bus_ready  <= (state_d == IDLE) || (state_d == GET_B);
      busy       <= (state_d != IDLE);
      res_valid  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and 3) driven by
// directed and random transactions, checked against a transaction-level model.
module tb_alu_op_sequencer;
  import alu_defs_pkg::*;

  logic       clock = 1'b0;
  logic       clear      [2];
  logic [7:0] bus_in     [2];
  logic [3:0] op_in      [2];
  logic       bus_valid  [2];
  logic       bus_ready  [2];
  logic [7:0] alu_a      [2];
  logic [7:0] alu_b      [2];
  logic [3:0] alu_opcode [2];
  logic [7:0] alu_result [2];
  logic [7:0] res_out    [2];
  logic       res_valid  [2];
  logic       res_ready  [2];
  logic       busy       [2];
  logic       err        [2];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_b   [2];

  always #5 clock = ~clock;

  // Behaviour of the 8-bit ALU; codes outside the set give A xor B.
  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return ~a;
      4'd3:    return 8'(9'd256 - {1'b0, a});
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result[0] = ref_alu(alu_opcode[0], alu_a[0], alu_b[0]);
  assign alu_result[1] = ref_alu(alu_opcode[1], alu_a[1], alu_b[1]);

  alu_op_sequencer #(.DATA_W(8), .OP_W(4), .SETTLE_CYCLES(1)) u_dut_s1 (
    .clock(clock), .clear(clear[0]), .bus_in(bus_in[0]), .op_in(op_in[0]),
    .bus_valid(bus_valid[0]), .bus_ready(bus_ready[0]), .alu_a(alu_a[0]),
    .alu_b(alu_b[0]), .alu_opcode(alu_opcode[0]), .alu_result(alu_result[0]),
    .res_out(res_out[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .busy(busy[0]), .err(err[0])
  );

  alu_op_sequencer #(.DATA_W(8), .OP_W(4), .SETTLE_CYCLES(3)) u_dut_s3 (
    .clock(clock), .clear(clear[1]), .bus_in(bus_in[1]), .op_in(op_in[1]),
    .bus_valid(bus_valid[1]), .bus_ready(bus_ready[1]), .alu_a(alu_a[1]),
    .alu_b(alu_b[1]), .alu_opcode(alu_opcode[1]), .alu_result(alu_result[1]),
    .res_out(res_out[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .busy(busy[1]), .err(err[1])
  );

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int i, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input int i, input string tag);
    check({tag, "_alu_a"}, i, 32'(alu_a[i]), 32'h0);
    check({tag, "_alu_b"}, i, 32'(alu_b[i]), 32'h0);
    check({tag, "_opcode"}, i, 32'(alu_opcode[i]), 32'h0);
    check({tag, "_res_valid"}, i, 32'(res_valid[i]), 32'h0);
    check({tag, "_busy"}, i, 32'(busy[i]), 32'h0);
    check({tag, "_err"}, i, 32'(err[i]), 32'h0);
    check({tag, "_bus_ready"}, i, 32'(bus_ready[i]), 32'h1);
  endtask

  task automatic do_reset(input int i);
    clear[i] = 1'b1; bus_valid[i] = 1'b0; res_ready[i] = 1'b0;
    bus_in[i] = 8'hEE; op_in[i] = 4'hE;
    tick();
    clear[i] = 1'b0;
    check_idle_reset(i, "reset");
    check("reset_res_out", i, 32'(res_out[i]), 32'h0);
    last_b[i] = 8'h00;
  endtask

  // One full transaction: A beat, gap idle cycles in GET_B, B beat (with a
  // different op_in), wait for the result, hold res_ready low, then release,
  // optionally with a competing bus_valid in the release cycle.
  task automatic run_op(input int i, input logic [7:0] a, input logic [3:0] op,
                        input logic [7:0] b, input int gap, input int hold,
                        input bit collide);
    logic       ill;
    logic [7:0] exp_res;
    int         exp_lat;
    int         lat;
`ifdef ALU_OPCODE_CHECK_EN
    ill = (op > 4'd3);
`else
    ill = 1'b0;
`endif
    exp_res = ill ? 8'h00 : ref_alu(op, a, b);
    exp_lat = ill ? 0 : settle_of(i);

    check("idle_ready", i, 32'(bus_ready[i]), 32'h1);
    bus_in[i] = a; op_in[i] = op; bus_valid[i] = 1'b1;
    tick();
    check("a_captured", i, 32'(alu_a[i]), 32'(a));
    check("op_captured", i, 32'(alu_opcode[i]), 32'(op));
    check("busy_get_b", i, 32'(busy[i]), 32'h1);

    bus_valid[i] = 1'b0; bus_in[i] = 8'($urandom); op_in[i] = 4'($urandom);
    for (int g = 0; g < gap; g++) begin
      tick();
      check("gap_ready", i, 32'(bus_ready[i]), 32'h1);
      check("gap_b_hold", i, 32'(alu_b[i]), 32'(last_b[i]));
    end

    bus_in[i] = b; op_in[i] = op ^ 4'h5; bus_valid[i] = 1'b1;
    tick();
    bus_valid[i] = 1'b0; bus_in[i] = 8'($urandom); op_in[i] = 4'($urandom);
    last_b[i] = b;
    check("b_captured", i, 32'(alu_b[i]), 32'(b));
    check("op_kept", i, 32'(alu_opcode[i]), 32'(op));

    lat = 0;
    while (res_valid[i] !== 1'b1 && lat < 20) begin
      check("settle_ready_low", i, 32'(bus_ready[i]), 32'h0);
      check("settle_a_stable", i, 32'(alu_a[i]), 32'(a));
      tick();
      lat++;
    end
    check("latency", i, 32'(lat), 32'(exp_lat));
    check("res_out", i, 32'(res_out[i]), 32'(exp_res));
    check("err", i, 32'(err[i]), 32'(ill));
    check("done_ready_low", i, 32'(bus_ready[i]), 32'h0);

    res_ready[i] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", i, 32'(res_valid[i]), 32'h1);
      check("hold_res_out", i, 32'(res_out[i]), 32'(exp_res));
    end

    res_ready[i] = 1'b1;
    if (collide) begin
      bus_valid[i] = 1'b1; bus_in[i] = ~a; op_in[i] = 4'h1;
    end
    tick();
    res_ready[i] = 1'b0; bus_valid[i] = 1'b0;
    check("release_valid", i, 32'(res_valid[i]), 32'h0);
    check("release_busy", i, 32'(busy[i]), 32'h0);
    check("release_err", i, 32'(err[i]), 32'h0);
    check("release_ready", i, 32'(bus_ready[i]), 32'h1);
    check("release_a_kept", i, 32'(alu_a[i]), 32'(a));
    check("release_res_hold", i, 32'(res_out[i]), 32'(exp_res));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      clear[i] = 1'b0; bus_valid[i] = 1'b0; res_ready[i] = 1'b0;
      bus_in[i] = 8'h00; op_in[i] = 4'h0; last_b[i] = 8'h00;
    end
    tick();
    do_reset(0);
    do_reset(1);

    // Basic AND, then OR/NOT/NEG back-to-back on the settle-1 instance.
    run_op(0, 8'd15, OP_AND, 8'd3, 0, 0, 1'b0);
    run_op(0, 8'd15, OP_OR,  8'd3, 0, 0, 1'b0);
    run_op(0, 8'd15, OP_NOT, 8'd3, 0, 0, 1'b0);
    run_op(0, 8'd15, OP_NEG, 8'd3, 0, 0, 1'b0);

    // Settle 3 with five cycles of backpressure.
    run_op(1, 8'd15, OP_OR, 8'd3, 0, 5, 1'b0);

    // Clear during SETTLE discards everything.
    bus_in[1] = 8'h77; op_in[1] = OP_OR; bus_valid[1] = 1'b1;
    tick();
    bus_in[1] = 8'h11;
    tick();
    bus_valid[1] = 1'b0;
    tick();
    clear[1] = 1'b1;
    tick();
    clear[1] = 1'b0;
    last_b[1] = 8'h00;
    check_idle_reset(1, "mid_clear");
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_clear_no_result", 1, 32'(res_valid[1]), 32'h0);
    end
    run_op(1, 8'h3C, OP_AND, 8'h0F, 0, 0, 1'b0);

    // Gaps in GET_B and a competing A beat during result release.
    run_op(0, 8'hA5, OP_OR, 8'h5A, 2, 1, 1'b1);
    run_op(1, 8'h81, OP_NEG, 8'h42, 1, 0, 1'b1);

    // Out-of-set opcode.
    run_op(0, 8'd15, 4'b0111, 8'd3, 0, 0, 1'b0);
    run_op(1, 8'hC3, 4'b1010, 8'h3C, 1, 2, 1'b0);

    // Random legal traffic on both instances.
    for (int n = 0; n < 40; n++) begin
      run_op(n % 2, 8'($urandom), 4'($urandom_range(3, 0)), 8'($urandom),
             int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
             1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side front end that drives the 8-bit combinational ALU (AND/OR/NOT/NEG opcode set) from a shared single-beat data bus.
- Collects operand A plus opcode, then operand B, over a valid/ready bus.
- Holds operands and opcode stable on the ALU inputs for a programmable settle window, then captures the ALU result into a Z register.
- Presents the result on a valid/ready output port.
- Sits between the CPU bus/control unit and the ALU, replacing hand-driven operand/opcode stimulus.

Parameters:
DATA_W, 8, operand/result width
OP_W, 4, opcode width
SETTLE_CYCLES, 1, cycles ALU inputs are held before result capture; legal 1..15; a value of 0 elaborates as 1

Ports:
clock  in  1  rising-edge clock
clear  in  1  synchronous active-high reset
bus_in  in  DATA_W  operand beat data
op_in  in  OP_W  opcode, sampled only with the operand-A beat
bus_valid  in  1  operand beat present
bus_ready  out  1  sequencer accepts an operand beat
alu_a  out  DATA_W  registered operand A to ALU
alu_b  out  DATA_W  registered operand B to ALU
alu_opcode  out  OP_W  registered opcode to ALU
alu_result  in  DATA_W  combinational ALU output
res_out  out  DATA_W  captured result (Z register)
res_valid  out  1  res_out valid
res_ready  in  1  consumer accepts result
busy  out  1  high in any state other than IDLE
err  out  1  illegal-opcode flag for the current result (see Optional Feature)

Behaviour:
- All state changes on rising clock edge. Clock and reset are fixed: one clock named clock; reset named clear, synchronous, active-high.
- clear=1 at an edge: state returns to IDLE, settle counter cleared.
  - Reset values: alu_a, alu_b, res_out = 0; alu_opcode = 4'b0000; res_valid = 0; busy = 0; err = 0; bus_ready = 1 from the following cycle.
  - clear has priority over every other event.
  - clear mid-operation discards all captured data; no partial result is ever presented.
- States:
  - IDLE: bus_ready=1. On bus_valid: capture bus_in into A and op_in into opcode, go to GET_B.
  - GET_B: bus_ready=1. On bus_valid: capture bus_in into B, load counter with SETTLE_CYCLES, go to SETTLE. op_in is ignored in this state.
  - SETTLE: bus_ready=0. Decrement the counter each cycle. In the cycle the counter equals 1: capture alu_result into res_out, go to DONE.
  - DONE: res_valid=1, bus_ready=0. On res_ready: go to IDLE; res_valid drops the next cycle.
- alu_a, alu_b and alu_opcode are driven directly from registers and change only on an accepted beat, never during SETTLE.
- Latency: with the B beat accepted at edge k, res_out is captured at edge k+SETTLE_CYCLES and res_valid is high from that edge.
- res_out holds its value after DONE until the next capture.
- Backpressure: DONE persists indefinitely while res_ready=0. bus_valid during SETTLE/DONE is not accepted.
- Simultaneous res_ready and bus_valid in DONE: the result completes; the new A beat is accepted no earlier than the following IDLE cycle.
- No arithmetic in this block; widths pass through unchanged.

Optional Feature:
Macro ALU_OPCODE_CHECK_EN.
- Defined: an opcode greater than 4'b0011 captured in IDLE is flagged illegal. B is still accepted. SETTLE is skipped and the block enters DONE the cycle after the B beat, with res_out=0 and err=1. err clears when leaving DONE.
- Undefined: every opcode is forwarded to the ALU unchanged and err is tied to 0.

Decomposition:
- Shared include/package alu_defs:
  - opcode constants OP_AND=4'b0000, OP_OR=4'b0001, OP_NOT=4'b0010, OP_NEG=4'b0011
  - DATA_W and OP_W defaults
  - state encodings IDLE/GET_B/SETTLE/DONE
- One sub-module: alu_seq_settle_counter, a 4-bit load/decrement counter with a terminal-count output, reused by later multi-cycle datapath control.

Test Plan:
- A=15, op=OP_AND, B=3, SETTLE_CYCLES=1, res_ready=1 -> res_out=8'h03, res_valid for exactly 1 cycle, one edge after the B beat.
- A=15 with OP_OR, OP_NOT, OP_NEG (B=3) back-to-back -> res_out 8'h0F, 8'hF0, 8'hF1 in order; bus_ready low during SETTLE/DONE each time.
- SETTLE_CYCLES=3, OP_OR, res_ready held 0 for 5 cycles -> capture 3 edges after the B beat; res_valid stays high and res_out stable until res_ready.
- clear asserted in SETTLE -> next cycle: IDLE, res_valid=0, alu_opcode=4'b0000, alu_a=alu_b=0; a following full op completes normally.
- bus_valid toggled 1/0 in GET_B, with op_in changed during the B beat -> only the original opcode is used; B is taken on the first valid edge.
- With ALU_OPCODE_CHECK_EN defined, op=4'b0111 -> DONE one cycle after B, res_out=0, err=1. Without the macro -> err=0 and ALU output captured.
